traffic_ctrl_multi: RTL
=======================

Name: traffic_ctrl_multi

Overview:
Parametrised N-approach traffic-light controller, the successor to the fixed four-output controller. It runs a round-robin phase sequencer with configurable green, yellow and all-red durations counted in timebase ticks. It skips approaches with no vehicle demand and supports an emergency pre-emption mode that forces a chosen phase green. It sits at the top of the intersection design, driving one 3-bit lamp group per approach.

Parameters:
NUM_PHASES, 4, number of approaches/phases served (>=2)
GREEN_TICKS, 20, green duration in tick_en pulses (>=1)
YELLOW_TICKS, 4, yellow duration in tick_en pulses (>=1)
ALLRED_TICKS, 2, all-red clearance duration in tick_en pulses (>=1)
CNT_W, 8, timer width; all *_TICKS values must be < 2**CNT_W
PH_W (localparam), max(1,$clog2(NUM_PHASES)), phase index width

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tick_en  input  1  timebase strobe; timers advance only on cycles where it is high
sensor  input  NUM_PHASES  per-approach vehicle demand, level-sensitive
emerg_req  input  1  emergency pre-emption request, level-sensitive
emerg_phase  input  PH_W  phase to force green; sampled while emerg_req=1
lights  output  3*NUM_PHASES  lamp group per phase p at [3p+2:3p] = {R,Y,G}; 100=red, 010=yellow, 001=green
active_phase  output  PH_W  phase currently green/yellow (last served during all-red)
state_o  output  2  00=ALLRED, 01=GREEN, 10=YELLOW, 11=EMERG
emerg_active  output  1  high while state=EMERG

Behaviour:
- Moore machine. All outputs decode only from registered state, phase and timer, with no combinational path from inputs.
- Reset (rst=1 at an edge): state=ALLRED, active_phase=NUM_PHASES-1, timer=ALLRED_TICKS-1, every lamp group=100, emerg_active=0. rst dominates all other inputs. Reset mid-cycle aborts the current phase immediately.
- Timer rule: on entry to a timed state the timer loads DUR-1. On a tick_en cycle, if timer==0 the state transitions, otherwise the timer decrements. With tick_en=0 nothing changes. Each timed state therefore lasts exactly DUR ticks.
- ALLRED: all groups 100. On expiry:
  - if emerg_req=1, go to EMERG with active_phase=emerg_phase;
  - otherwise go to GREEN with the next phase, searching (active_phase+1) mod NUM_PHASES round-robin for the first phase with sensor=1;
  - if no sensor is high, take active_phase+1 (fixed-time fallback);
  - a phase that is the only one demanded is re-served after ALLRED.
- GREEN: the active group shows 001 and all others 100.
  - If emerg_req=1 and emerg_phase==active_phase, go to EMERG on the next edge (no tick required), keeping the lamps green.
  - If emerg_req=1 and emerg_phase!=active_phase, go to YELLOW on the next edge, truncating green.
  - Otherwise go to YELLOW on timer expiry.
- YELLOW: the active group shows 010 and all others 100. It always runs its full YELLOW_TICKS, then ALLRED. It is never truncated by emergency.
- EMERG: group emerg_phase shows 001, all others 100, emerg_active=1, timer idle.
  - When emerg_req falls, go to YELLOW on the same phase (full yellow, then ALLRED, then round-robin from emerg_phase+1).
  - A change of emerg_phase while in EMERG is handled as emerg_req falling: go to YELLOW, then ALLRED, then EMERG on the new phase.
- Invariant: at most one group is non-red in any cycle, and green never follows green without YELLOW+ALLRED in between.
- emerg_phase >= NUM_PHASES is ignored (treated as emerg_req=0).
- Index wrap: phase NUM_PHASES-1 is followed by phase 0.

Test Plan:
1. NUM_PHASES=4, G=3, Y=2, AR=1, tick_en=1, sensor=1111, rst high 2 cycles then low -> lights all red for 1 cycle; phase0 001 for 3 cycles, 010 for 2, all red for 1; then phase1 green; sequence 0,1,2,3,0 repeats every 24 cycles.
2. Same parameters, sensor=0100 -> only phase 2 is served: green 3, yellow 2, all-red 1, repeating. sensor=0000 -> fixed cycle 0,1,2,3.
3. tick_en pulsed 1 cycle in 4 -> each state's duration is ×4 cycles; lights stay frozen on cycles with tick_en=0.
4. Emergency: raise emerg_req with emerg_phase=2 during phase0 green cycle 1 -> next edge YELLOW on phase0 (2 ticks), ALLRED 1 tick, then EMERG (group2=001, emerg_active=1) held for 10 cycles. Drop emerg_req -> phase2 yellow 2, all-red 1, then phase3 green.
5. emerg_req asserted while phase2 is already green with emerg_phase=2 -> state_o=11 on the next edge, lamps unchanged, no yellow.
6. Assert rst during a YELLOW -> next edge all red, state_o=00, active_phase=3. After release, phase0 is green after ALLRED_TICKS. A checker confirms the at-most-one-non-red invariant throughout.

Source files
------------

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: N-approach round-robin traffic-light sequencer with demand skipping and emergency pre-emption
module traffic_ctrl_multi #(
  parameter int NUM_PHASES   = 4,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int CNT_W        = 8,
  localparam int PH_W = ($clog2(NUM_PHASES) < 1) ? 1 : $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic [NUM_PHASES-1:0]   sensor,
  input  logic                    emerg_req,
  input  logic [PH_W-1:0]         emerg_phase,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PH_W-1:0]         active_phase,
  output logic [1:0]              state_o,
  output logic                    emerg_active
);
  typedef enum logic [1:0] {ALLRED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, EMERG = 2'b11} state_e;
  state_e           state_q;
  logic [PH_W-1:0]  phase_q;
  logic [CNT_W-1:0] timer_q;
  logic [PH_W-1:0]  rr_ph;
  logic [PH_W-1:0]  idx;
  logic             emerg_v;
  logic             expired;
  assign emerg_v = emerg_req && (32'(emerg_phase) < NUM_PHASES);
  assign expired = tick_en && timer_q == '0;
  // Scan farthest-first so the nearest demanded phase after the current one wins.
  always_comb begin
    rr_ph = PH_W'((32'(phase_q) + 1) % NUM_PHASES);
    idx   = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = PH_W'((32'(phase_q) + k) % NUM_PHASES);
      if (sensor[idx]) rr_ph = idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALLRED;
      phase_q <= PH_W'(NUM_PHASES - 1);
      timer_q <= CNT_W'(ALLRED_TICKS - 1);
    end else begin
      case (state_q)
        ALLRED: begin
          if (expired && emerg_v) begin
            state_q <= EMERG;
            phase_q <= emerg_phase;
          end else if (expired) begin
            state_q <= GREEN;
            phase_q <= rr_ph;
            timer_q <= CNT_W'(GREEN_TICKS - 1);
          end else if (tick_en) timer_q <= timer_q - 1'b1;
        end
        GREEN: begin
          if (emerg_v && emerg_phase == phase_q) state_q <= EMERG;
          else if (emerg_v || expired) begin
            state_q <= YELLOW;
            timer_q <= CNT_W'(YELLOW_TICKS - 1);
          end else if (tick_en) timer_q <= timer_q - 1'b1;
        end
        YELLOW: begin
          if (expired) begin
            state_q <= ALLRED;
            timer_q <= CNT_W'(ALLRED_TICKS - 1);
          end else if (tick_en) timer_q <= timer_q - 1'b1;
        end
        EMERG: begin
          if (!emerg_v || emerg_phase != phase_q) begin
            state_q <= YELLOW;
            timer_q <= CNT_W'(YELLOW_TICKS - 1);
          end
        end
      endcase
    end
  end
  always_comb begin
    lights = {NUM_PHASES{3'b100}};
    if (state_q == GREEN || state_q == EMERG) lights[3*phase_q +: 3] = 3'b001;
    else if (state_q == YELLOW) lights[3*phase_q +: 3] = 3'b010;
  end
  assign active_phase = phase_q;
  assign state_o      = state_q;
  assign emerg_active = state_q == EMERG;
endmodule
